// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory boot loader.
package imem_loader_pkg;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, CHK, DONE, ERR} state_t;

  // States in which the loader takes stream bytes.
  function automatic logic accepts(state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHK);
  endfunction
endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream MSB-first into 32-bit words; word_ready marks the 4th byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_ready
);
  logic [23:0] sh;
  logic [1:0]  idx;

  // The completed word is presented combinationally alongside the 4th byte.
  assign word_ready = push && (idx == 2'(BYTES_PER_WORD - 1));
  assign word       = {sh, data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      idx <= '0;
    end else if (clr) begin
      sh  <= '0;
      idx <= '0;
    end else if (push) begin
      sh  <= {sh[15:0], data};
      idx <= idx + 2'd1;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer; holds the CPU stalled until the image is in.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        load_req,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        cpu_run,
  output logic        err
);
  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t DATA_END = CHK;
  logic [7:0] chk;
`else
  localparam state_t DATA_END = DONE;
`endif

  state_t      state, nxt;
  logic [15:0] len, k, len_n;
  logic        fire, restart, word_ready;
  logic [31:0] word;

  assign fire    = in_valid && in_ready;
  assign restart = load_req && (state == DONE || state == ERR);
  assign len_n   = {len[15:8], in_data};

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (restart),
    .push      (fire && state == DATA),
    .data      (in_data),
    .word      (word),
    .word_ready(word_ready)
  );

  always_comb begin
    nxt = state;
    if (restart) nxt = LEN_HI;
    else if (fire) begin
      case (state)
        LEN_HI: nxt = LEN_LO;
        LEN_LO: begin
          if ({1'b0, len_n} > MAX_W) nxt = ERR;
          else if (len_n == 16'd0)   nxt = DATA_END;
          else                       nxt = DATA;
        end
        DATA: if (word_ready && k == len - 16'd1) nxt = DATA_END;
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: nxt = (in_data == chk) ? DONE : ERR;
`endif
        default: ;
      endcase
    end
  end

  // Status outputs are registered from the next state so they change with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LEN_HI;
      in_ready  <= 1'b1;
      imem_we   <= 1'b0;
      imem_addr <= BASE_ADDR;
      imem_wd   <= '0;
      cpu_run   <= 1'b0;
      err       <= 1'b0;
      len       <= '0;
      k         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk       <= '0;
`endif
    end else begin
      state    <= nxt;
      in_ready <= accepts(nxt);
      cpu_run  <= (nxt == DONE);
      err      <= (nxt == ERR);
      imem_we  <= 1'b0;
      if (restart) begin
        len <= '0;
        k   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk <= '0;
`endif
      end else if (fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk <= chk ^ in_data;
`endif
        if (state == LEN_HI) len[15:8] <= in_data;
        if (state == LEN_LO) begin
          len[7:0] <= in_data;
          k        <= '0;
        end
        if (word_ready) begin
          imem_we   <= 1'b1;
          imem_addr <= BASE_ADDR + {14'd0, k, 2'b00};
          imem_wd   <= word;
          k         <= k + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stream model pushes expected writes, monitor pops.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int MAXW = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, load_req = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, imem_we, cpu_run, err;
  logic [31:0] imem_addr, imem_wd;

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .load_req(load_req), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wd(imem_wd), .cpu_run(cpu_run), .err(err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        run;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %h wd %h, expected no write", imem_addr, imem_wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", imem_addr, e.addr);
        check("write_wd", imem_wd, e.wd);
        check("run_at_write", cpu_run, e.run);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready 0 for byte %h, expected 1", b);
    end
    @(posedge clk);
  endtask

  // Appends the XOR of all stream bytes so far (optionally corrupted) when the checksum is built in.
  task automatic push_chk(input logic [7:0] flip);
    logic [7:0] x = 8'h00;
    if (CHK_EN) begin
      foreach (stim[i]) x ^= stim[i];
      stim.push_back(x ^ flip);
    end
  endtask

  // Reference: derive writes and final outcome from the stream rules, then drive it.
  task automatic run_image(input int gap, input bit rnd);
    int n;
    logic [7:0] x;
    bit exp_run, exp_err;
    wr_t e;
    n = int'({stim[0], stim[1]});
    if (n > MAXW) begin
      exp_run = 1'b0;
      exp_err = 1'b1;
    end else begin
      for (int w = 0; w < n; w++) begin
        e.addr = BASE + 32'(4 * w);
        e.wd   = {stim[2+4*w], stim[3+4*w], stim[4+4*w], stim[5+4*w]};
        e.run  = (w == n - 1) && !CHK_EN;
        exp_q.push_back(e);
      end
      if (CHK_EN) begin
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * n; i++) x ^= stim[i];
        exp_run = (stim[2+4*n] == x);
      end else exp_run = 1'b1;
      exp_err = !exp_run;
    end
    for (int i = 0; i < stim.size(); i++) begin
      int g = 0;
      if (rnd) g = $urandom_range(0, 3);
      else if (i >= 2 && (i - 2) % 4 == 2) g = gap;
      send_byte(stim[i], g);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("cpu_run_final", cpu_run, exp_run);
    check("err_final", err, exp_err);
    check("in_ready_final", in_ready, 1'b0);
    @(negedge clk);
    check("writes_drained", exp_q.size(), 0);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("cpu_run_reload", cpu_run, 1'b0);
    check("err_reload", err, 1'b0);
    check("in_ready_reload", in_ready, 1'b1);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_imem_we", imem_we, 1'b0);
    check("rst_imem_addr", imem_addr, BASE);
    check("rst_imem_wd", imem_wd, 32'h0);
    check("rst_cpu_run", cpu_run, 1'b0);
    check("rst_err", err, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // Two-word image at full rate, then with mid-word stalls.
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    push_chk(8'h00);
    run_image(0, 1'b0);
    run_image(3, 1'b0);

    // Oversized length is rejected.
    stim = '{8'h00, 8'h41};
    run_image(0, 1'b0);

    // Empty image, and with checksum a bad checksum on it.
    stim = '{8'h00, 8'h00};
    push_chk(8'h00);
    run_image(0, 1'b0);
    if (CHK_EN) begin
      stim = '{8'h00, 8'h00};
      push_chk(8'hFF);
      run_image(0, 1'b0);
    end

    // Reset mid-word, then full reload.
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    stim = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'hEF, 8'h01};
    push_chk(8'h00);
    run_image(0, 1'b0);

    // One-word image with good and corrupted checksum.
    if (CHK_EN) begin
      stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
      push_chk(8'h00);
      run_image(0, 1'b0);
      stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
      push_chk(8'h01);
      run_image(0, 1'b0);
    end

    // Largest legal image.
    stim = '{8'h00, 8'h40};
    for (int i = 0; i < 4 * MAXW; i++) stim.push_back(8'($urandom));
    push_chk(8'h00);
    run_image(0, 1'b0);

    // Random images with random stalls, occasional oversize or bad checksum.
    for (int t = 0; t < 12; t++) begin
      int n;
      if ($urandom_range(0, 5) == 0) n = $urandom_range(MAXW + 1, 65535);
      else n = $urandom_range(0, 8);
      stim.delete();
      stim.push_back(8'(n >> 8));
      stim.push_back(8'(n));
      if (n <= MAXW) begin
        for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
        push_chk(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      end
      run_image(0, (t % 2) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
